// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic sum
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder slice stepped LSB-first, one bit per cycle.
// Optional SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    sa_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .c_out (fa_cout),
        .sum   (fa_sum)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Status flags depend only on the state register.
    assign ready = (state == IDLE);
    assign busy  = (state == RUN) || (state == DONE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter from the MSB so bit 0 lands at sum[0] after WIDTH steps.
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_cout;
                    if (last_bit) begin
                        c_out <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        ovf   <= carry ^ fa_cout;
`else
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8; ovf checked when SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    int   pushed    = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_seen++;
            check("expect_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("c_out", 64'(c_out), 64'(e.c_out));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check("ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum   = s;
        e.c_out = co;
        e.ovf   = ov;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Called in the post-edge phase; waits (bounded) until the controller is idle.
    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 64'(ready), 64'd1);
    endtask

    // Issues one accepted start; returns 1 time unit after the accept edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        wait_ready();
        start = 1'b1;
        a     = av;
        b     = bv;
        c_in  = ci;
        @(posedge clk); #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, busy_n, done_n, seen0, n;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'h00);
        check("rst_c_out", 64'(c_out), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;

        // Basic add with latency and busy-length measurement.
        push_exp(8'h10, 1'b0, 1'b0);
        issue(8'h0F, 8'h01, 1'b0);
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                done_at = k;
            end
            @(posedge clk); #1;
        end
        check("done_latency", 64'(done_at), 64'd8);
        check("busy_cycles", 64'(busy_n), 64'd9);
        check("done_pulses", 64'(done_n), 64'd1);

        push_exp(8'h00, 1'b1, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        push_exp(8'hFF, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1);
        push_exp(8'h80, 1'b0, 1'b1);
        issue(8'h7F, 8'h01, 1'b0);

        // Start pulse during RUN must be ignored.
        wait_ready();
        seen0 = done_seen;
        push_exp(8'h46, 1'b0, 1'b0);
        issue(8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'hAA;
        @(posedge clk); #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        check("guard_done_count", 64'(done_seen - seen0), 64'd1);
        check("guard_idle", 64'(ready), 64'd1);

        // Abort with reset sampled on the 4th RUN edge.
        issue(8'h55, 8'h22, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'h00);
        check("abort_c_out", 64'(c_out), 64'd0);
        rst   = 1'b0;
        seen0 = done_seen;
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(done_seen - seen0), 64'd0);
        push_exp(8'h08, 1'b0, 1'b0);
        issue(8'h03, 8'h05, 1'b0);

        // Held start: re-accept on the first IDLE cycle, i.e. WIDTH+2 cycles apart.
        wait_ready();
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        c_in  = 1'b0;
        push_exp(8'h03, 1'b0, 1'b0);
        push_exp(8'h03, 1'b0, 1'b0);
        @(posedge clk); #1;
        n = 0;
        while (ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_idle_gap", 64'(n), 64'd9);
        @(posedge clk); #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        check("b2b_reaccept", 64'(busy), 64'd1);

        wait_ready();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_total", 64'(done_seen), 64'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that shares one `full_adder` slice across all bit positions of a WIDTH-bit addition. It accepts one operand pair per start, steps the slice LSB-first for one bit per cycle, and carries the ripple carry in a register between steps. It then presents the registered sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a WIDTH-bit ripple array in the arithmetic datapath.

## Interface
- `WIDTH`, default 8: operand and sum width, legal range 2..64.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; accepted only when `ready`=1.
- `a`  input  WIDTH  operand A; sampled on the accept edge only.
- `b`  input  WIDTH  operand B; sampled on the accept edge only.
- `c_in`  input  1  carry-in; sampled on the accept edge only.
- `ready`  output  1  high in IDLE only.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse, high in DONE.
- `sum`  output  WIDTH  registered result; held until the next accept.
- `c_out`  output  1  registered final carry; held like `sum`.

## Operation
- States:
  - IDLE: `ready`=1. On `start`=1, latch `a`, `b` and `c_in` into the operand shift registers and the carry register, clear `cnt`, and go to RUN.
  - RUN: the slice is fed `a_sh[0]`, `b_sh[0]` and `carry`. Each cycle:
    - shift the slice sum into `sum` from the MSB side (shift right);
    - shift the operand registers right;
    - load the slice `c_out` into `carry`;
    - increment `cnt`.
    - When `cnt`=WIDTH-1, instead load `c_out` from the slice carry and go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `cnt` is $clog2(WIDTH) bits wide. It never wraps because the terminal compare happens at WIDTH-1.
- `sum` is modulo 2^WIDTH. The true result is {`c_out`, `sum`}, WIDTH+1 bits.
- `start` in RUN or DONE is ignored, with no queuing. Operand changes after the accept edge have no effect.
- `sum` and `c_out` are not cleared on accept. They change bit by bit during RUN and are only valid while `done`=1 and afterwards in IDLE.
- `rst` in any state aborts the operation:
  - state goes to IDLE and `cnt`, the operand registers and `carry` clear to 0;
  - `sum`=0 and `c_out`=0;
  - no `done` is issued for the aborted operation.
- If `rst` and `start` are high on the same edge, reset wins and the start is dropped.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `sum`=0, `c_out`=0, state IDLE.
- `ready`, `busy` and `done` are decoded combinationally from the state register only, never from inputs.
- Latency: accept on edge E0. Bit i is computed on edge E(i+1). `done` is high in the cycle after edge E(WIDTH) and low after E(WIDTH+1).
- Throughput: one addition per WIDTH+2 cycles, counting back-to-back starts with `start` held high.
- Holding `start` high continuously re-accepts on the first IDLE cycle after DONE.

## Configuration
- Macro: `SERIAL_ADDER_OVERFLOW_EN`.
- When defined, an extra output `ovf` (1 bit) is present:
  - `ovf` is the two's-complement overflow, equal to the carry into bit WIDTH-1 XOR the final carry-out.
  - It is captured on the same edge as `c_out`, held like `sum`, and resets to 0.
- When undefined, the port and its capture register do not exist. All other behaviour and timing are identical.

## Structure
- Shared package `serial_adder_pkg`:
  - state enum `sa_state_t` with values IDLE, RUN, DONE (2-bit encoding);
  - constant `SA_DEFAULT_WIDTH` = 8.
- Sub-module: one instance of the existing `full_adder` as the bit slice, with ports `a`, `b`, `c_in`, `c_out`, `sum`.
- The controller contains only the FSM, `cnt`, the operand and sum shift registers, and the carry register.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `rst` for 2 cycles -> `ready`=1, `busy`=0, `done`=0, `sum`=8'h00, `c_out`=0.
- Basic add: `a`=8'h0F, `b`=8'h01, `c_in`=0 -> `sum`=8'h10, `c_out`=0. `done` is high exactly in the cycle after the 8th RUN edge, and `busy` is high for 9 cycles.
- Carry-out: `a`=8'hFF, `b`=8'h01, `c_in`=0 -> `sum`=8'h00, `c_out`=1, `ovf`=0 when enabled. With `a`=8'hFF, `b`=8'hFF, `c_in`=1 -> `sum`=8'hFF, `c_out`=1.
- Signed overflow, with the macro defined: `a`=8'h7F, `b`=8'h01 -> `sum`=8'h80, `c_out`=0, `ovf`=1.
- Busy guard: start `a`=8'h12, `b`=8'h34, then pulse `start` with `a`=8'hAA, `b`=8'hAA during RUN -> result `sum`=8'h46, and only one `done` pulse.
- Abort: assert `rst` on the 4th RUN edge -> the next cycle is IDLE with all outputs 0 and no `done`. A following start with `a`=8'h03, `b`=8'h05 -> `sum`=8'h08.
